// File: rtl/mode_pkg.sv
// Mode encodings shared between the start/LFSR mode controller and the mode code receiver.
package mode_pkg;

    typedef enum logic [1:0] {
        MODE_SEED = 2'b01,
        MODE_RUN  = 2'b10,
        MODE_IDLE = 2'b11
    } mode_t;

    localparam logic [1:0] MODE_ILLEGAL = 2'b00;

    function automatic logic is_legal(input logic [1:0] code);
        return code != MODE_ILLEGAL;
    endfunction

endpackage

// File: rtl/code_stable_filter.sv
// Input register plus stability filter: strobes when the registered code has held its
// value long enough to be trusted.
module code_stable_filter
    import mode_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] code_i,
    output logic [1:0] code_q_o,
    output logic [1:0] cand_o,
    output logic       stable_o
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [1:0]    code_q;
    logic [1:0]    cand_q, cand_d;
    logic [CW-1:0] stab_cnt_q, stab_cnt_d;

    always_comb begin
        cand_d     = cand_q;
        stab_cnt_d = stab_cnt_q;
        if (code_q != cand_q) begin
            cand_d     = code_q;
            stab_cnt_d = '0;
        end else if (stab_cnt_q != CNT_MAX) begin
            stab_cnt_d = stab_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            code_q     <= MODE_IDLE;
            cand_q     <= MODE_IDLE;
            stab_cnt_q <= '0;
        end else begin
            code_q     <= code_i;
            cand_q     <= cand_d;
            stab_cnt_q <= stab_cnt_d;
        end
    end

    // Fires only on the edge where the counter reaches its limit, not while it sits there.
    assign stable_o = (code_q == cand_q) && (stab_cnt_q == CNT_MAX - 1'b1);
    assign code_q_o = code_q;
    assign cand_o   = cand_q;

endmodule

// File: rtl/mode_code_rx.sv
// Receiver for the 2-bit game-mode code: commit, control pulses, dwell counter, error flag.
// Define MODE_HIST_EN to add the mode_hist output (4-deep history of committed modes).
module mode_code_rx
    import mode_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int DWELL_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         code_in,
    input  logic               advance,
    output logic [1:0]         mode,
    output logic               mode_valid,
    output logic               mode_chg,
    output logic               seed_load,
    output logic               step_en,
    output logic [DWELL_W-1:0] dwell_cnt,
`ifdef MODE_HIST_EN
    output logic [7:0]         mode_hist,
`endif
    output logic               err
);

    logic [1:0] code_q;
    logic [1:0] cand;
    logic       stable;
    logic       commit;
    logic       change;

    mode_t               mode_q, mode_d;
    logic                valid_q, valid_d;
    logic                pend_q, pend_d;
    logic                chg_q, chg_d;
    logic                seed_q, seed_d;
    logic                step_q, step_d;
    logic                err_q, err_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;

    code_stable_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk     (clk),
        .reset   (reset),
        .code_i  (code_in),
        .code_q_o(code_q),
        .cand_o  (cand),
        .stable_o(stable)
    );

    assign commit = stable && is_legal(cand);
    assign change = commit && (cand != mode_q);

    // pend_q marks the commit edge so the change pulses land one cycle after the new mode.
    always_comb begin
        mode_d  = mode_q;
        valid_d = valid_q;
        dwell_d = dwell_q;
        if (commit) begin
            mode_d  = mode_t'(cand);
            valid_d = 1'b1;
        end
        pend_d = change;
        chg_d  = pend_q;
        seed_d = pend_q && (mode_q == MODE_SEED);
        step_d = advance && (mode_q == MODE_RUN) && !commit;
        err_d  = err_q || (code_q == MODE_ILLEGAL);
        if (change) begin
            dwell_d = '0;
        end else if (advance && valid_q && (dwell_q != '1)) begin
            dwell_d = dwell_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q  <= MODE_IDLE;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            chg_q   <= 1'b0;
            seed_q  <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
            dwell_q <= '0;
        end else begin
            mode_q  <= mode_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            chg_q   <= chg_d;
            seed_q  <= seed_d;
            step_q  <= step_d;
            err_q   <= err_d;
            dwell_q <= dwell_d;
        end
    end

`ifdef MODE_HIST_EN
    logic [7:0] hist_q, hist_d;

    always_comb begin
        hist_d = hist_q;
        if (change) begin
            hist_d = {hist_q[5:0], cand};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_q <= 8'hFF;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign mode_hist = hist_q;
`endif

    assign mode       = mode_q;
    assign mode_valid = valid_q;
    assign mode_chg   = chg_q;
    assign seed_load  = seed_q;
    assign step_en    = step_q;
    assign dwell_cnt  = dwell_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mode_code_rx.sv
// Bench for mode_code_rx: phase table with end-of-phase constants plus a per-cycle
// reference model feeding an expected-output queue.
module tb_mode_code_rx;

    localparam int STABLE = 4;

    typedef struct packed {
        logic [1:0]  mode;
        logic        valid;
        logic        chg;
        logic        seed;
        logic        step;
        logic [15:0] dwell;
        logic        err;
    } outs_t;

    typedef struct {
        logic        rst;
        logic [1:0]  code;
        logic        adv;
        int          cycles;
        logic [1:0]  expMode;
        logic        expValid;
        logic [15:0] expDwell;
        logic        expErr;
    } phase_t;

    logic        clk;
    logic        reset;
    logic [1:0]  codeIn;
    logic        advance;
    logic [1:0]  mode;
    logic        modeValid;
    logic        modeChg;
    logic        seedLoad;
    logic        stepEn;
    logic [15:0] dwellCnt;
    logic        err;
`ifdef MODE_HIST_EN
    logic [7:0]  modeHist;
`endif

    int total = 0;
    int bad = 0;
    int cycleNum = 0;
    outs_t expQ[$];

    logic [1:0]  mMode;
    logic        mValid, mChg, mSeed, mStep, mErr, mPend;
    logic [15:0] mDwell;
    logic [1:0]  runVal;
    int          runLen;
    logic [1:0]  prevSample;

    phase_t phases[15];

    mode_code_rx #(
        .STABLE_CYCLES(STABLE),
        .DWELL_W(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .code_in   (codeIn),
        .advance   (advance),
        .mode      (mode),
        .mode_valid(modeValid),
        .mode_chg  (modeChg),
        .seed_load (seedLoad),
        .step_en   (stepEn),
        .dwell_cnt (dwellCnt),
`ifdef MODE_HIST_EN
        .mode_hist (modeHist),
`endif
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour expressed as run lengths of identical code_in samples: a code
    // commits on the sample that completes STABLE+2 equal samples in a row.
    task automatic modelEdge(input logic r, input logic [1:0] c, input logic a);
        logic commit;
        logic change;
        if (!r) begin
            mMode = 2'b11; mValid = 0; mChg = 0; mSeed = 0; mStep = 0;
            mErr = 0; mPend = 0; mDwell = 0;
            runVal = 2'b11; runLen = 2; prevSample = 2'b11;
        end else begin
            if (prevSample == 2'b00) mErr = 1'b1;
            if (c == runVal) begin
                if (runLen < 1000) runLen++;
            end else begin
                runVal = c;
                runLen = 1;
            end
            commit = (runLen == STABLE + 2) && (runVal != 2'b00);
            change = commit && (runVal != mMode);
            mChg  = mPend;
            mSeed = mPend && (mMode == 2'b01);
            mStep = a && (mMode == 2'b10) && !commit;
            if (change) mDwell = 16'h0000;
            else if (a && mValid && (mDwell != 16'hFFFF)) mDwell = mDwell + 16'h0001;
            mPend = change;
            if (commit) begin
                mMode  = runVal;
                mValid = 1'b1;
            end
            prevSample = c;
        end
    endtask

    task automatic checkValue(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic checkOutput();
        outs_t act;
        outs_t exp;
        act = '{mode: mode, valid: modeValid, chg: modeChg, seed: seedLoad,
                step: stepEn, dwell: dwellCnt, err: err};
        total++;
        if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_empty cycle=%0d", cycleNum);
        end else begin
            exp = expQ.pop_front();
            if (act != exp) begin
                bad++;
                $display("[TB] FAIL cycle_%0d got mode=%b valid=%b chg=%b seed=%b step=%b dwell=%h err=%b want mode=%b valid=%b chg=%b seed=%b step=%b dwell=%h err=%b",
                         cycleNum, act.mode, act.valid, act.chg, act.seed, act.step, act.dwell, act.err,
                         exp.mode, exp.valid, exp.chg, exp.seed, exp.step, exp.dwell, exp.err);
            end
        end
    endtask

    // One clock: drive on the falling edge, predict, then sample just after the rising edge.
    task automatic applyStimulus(input logic r, input logic [1:0] c, input logic a);
        @(negedge clk);
        reset   = r;
        codeIn  = c;
        advance = a;
        modelEdge(r, c, a);
        expQ.push_back('{mode: mMode, valid: mValid, chg: mChg, seed: mSeed,
                         step: mStep, dwell: mDwell, err: mErr});
        @(posedge clk);
        #1;
        cycleNum++;
        checkOutput();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycleNum);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int modeEdge;
        int chgEdge;
        int chgCount;
        int seedCount;

        reset   = 1'b0;
        codeIn  = 2'b10;
        advance = 1'b0;
        modelEdge(1'b0, 2'b10, 1'b0);

        //             rst   code   adv  cycles    mode  valid dwell     err
        phases[0]  = '{1'b0, 2'b10, 1'b0, 2,       2'b11, 1'b0, 16'd0,     1'b0};
        phases[1]  = '{1'b1, 2'b01, 1'b0, 8,       2'b01, 1'b1, 16'd0,     1'b0};
        phases[2]  = '{1'b1, 2'b10, 1'b0, 8,       2'b10, 1'b1, 16'd0,     1'b0};
        phases[3]  = '{1'b1, 2'b10, 1'b1, 7,       2'b10, 1'b1, 16'd7,     1'b0};
        phases[4]  = '{1'b1, 2'b11, 1'b0, 3,       2'b10, 1'b1, 16'd7,     1'b0};
        phases[5]  = '{1'b1, 2'b10, 1'b1, 8,       2'b10, 1'b1, 16'd15,    1'b0};
        phases[6]  = '{1'b1, 2'b00, 1'b0, 10,      2'b10, 1'b1, 16'd15,    1'b1};
        phases[7]  = '{1'b1, 2'b11, 1'b1, 8,       2'b11, 1'b1, 16'd2,     1'b1};
        phases[8]  = '{1'b1, 2'b11, 1'b1, 65540,   2'b11, 1'b1, 16'hFFFF,  1'b1};
        phases[9]  = '{1'b0, 2'b01, 1'b1, 2,       2'b11, 1'b0, 16'd0,     1'b0};
        phases[10] = '{1'b1, 2'b11, 1'b0, 5,       2'b11, 1'b1, 16'd0,     1'b0};
        phases[11] = '{1'b1, 2'b01, 1'b0, 3,       2'b11, 1'b1, 16'd0,     1'b0};
        phases[12] = '{1'b0, 2'b01, 1'b0, 1,       2'b11, 1'b0, 16'd0,     1'b0};
        phases[13] = '{1'b1, 2'b01, 1'b0, 5,       2'b11, 1'b0, 16'd0,     1'b0};
        phases[14] = '{1'b1, 2'b01, 1'b0, 2,       2'b01, 1'b1, 16'd0,     1'b0};

        for (int p = 0; p < 15; p++) begin
            for (int k = 0; k < phases[p].cycles; k++) begin
                applyStimulus(phases[p].rst, phases[p].code, phases[p].adv);
            end
            checkValue($sformatf("phase%0d_mode", p), int'(mode), int'(phases[p].expMode));
            checkValue($sformatf("phase%0d_valid", p), int'(modeValid), int'(phases[p].expValid));
            checkValue($sformatf("phase%0d_dwell", p), int'(dwellCnt), int'(phases[p].expDwell));
            checkValue($sformatf("phase%0d_err", p), int'(err), int'(phases[p].expErr));
        end

        // Commit latency from reset: code held from sample 0 commits at sample 5, pulses at 6.
        applyStimulus(1'b0, 2'b10, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0);
        modeEdge  = -1;
        chgEdge   = -1;
        chgCount  = 0;
        seedCount = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 2'b01, 1'b0);
            if ((mode == 2'b01) && (modeEdge < 0)) modeEdge = i;
            if (modeChg) begin
                chgCount++;
                chgEdge = i;
            end
            if (seedLoad) seedCount++;
        end
        checkValue("latency_mode_edge", modeEdge, 5);
        checkValue("latency_chg_edge", chgEdge, 6);
        checkValue("latency_chg_count", chgCount, 1);
        checkValue("latency_seed_count", seedCount, 1);
        checkValue("scoreboard_drained", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
